hsci_miso_aligner: RTL and testbench
====================================

Name: hsci_miso_aligner

Overview:
- Sits between the ISERDES byte output and the HSCI master decoder input (mdec_data), in the hsci_pclk domain.
- Raw ISERDES bytes carry an arbitrary bit offset. The block finds the bit offset at which a known training byte appears and confirms it over consecutive bytes.
- Once confirmed, it delivers byte-aligned MISO data with lock status, a timeout flag and a relock counter, which can be mapped into the status registers.

Parameters:
- SYNC_PATTERN, 8'hA5, training byte to search for. It must not equal any of its own non-zero bit rotations.
- SYNC_COUNT, 4, consecutive matches at one offset needed to declare lock (including the first match). Legal range 2..15.
- HUNT_TIMEOUT, 4096, cycles spent outside LOCKED before hunt_timeout is set. Counter is 16-bit, so the value must be at most 65535.

Ports:
- hsci_pclk  in  1  link clock; the only clock.
- hsci_rst_sync  in  1  synchronous, active-high reset.
- enable  in  1  when high, alignment runs; when low, the block is forced to IDLE.
- realign  in  1  single-cycle pulse that forces a new hunt.
- clear_errors  in  1  clears hunt_timeout and relock_cnt.
- din  in  8  raw ISERDES byte, valid every cycle.
- dout  out  8  aligned byte, feeds mdec_data.
- dout_valid  out  1  high only while in LOCKED.
- locked  out  1  high in LOCKED.
- offset  out  3  selected bit offset.
- state  out  2  current FSM state, for debug.
- hunt_timeout  out  1  sticky flag: timeout reached.
- relock_cnt  out  8  saturating count of LOCKED→HUNT transitions.

Behaviour:
- Reset: hsci_rst_sync is synchronous and active-high, and takes priority over every other input. Reset values:
  - all outputs 0;
  - state IDLE;
  - the internal prev register, timeout counter and match counter all 0.
- Window and candidates:
  - prev <= din every cycle.
  - w = {prev, din} is 16 bits wide.
  - cand[k] = w[k+7:k] for k = 0..7.
- Output timing:
  - When locked: dout(t+1) = cand[offset](t).
  - When not locked: dout = 8'h00 and dout_valid = 0.
  - Latency is 1 cycle from the window to dout.
- FSM states are IDLE=0, HUNT=1, VERIFY=2, LOCKED=3.
  - IDLE: offset holds 0. Goes to HUNT when enable = 1.
  - HUNT: if any cand[k] == SYNC_PATTERN, then
    - offset <= lowest matching k;
    - match counter <= 1;
    - go to VERIFY.
  - VERIFY:
    - If cand[offset] == SYNC_PATTERN, the match counter increments. When it reaches SYNC_COUNT, go to LOCKED.
    - On any mismatch, go to HUNT and ignore other offsets in that cycle.
  - LOCKED: stays in LOCKED; data content is not checked.
- Leaving LOCKED:
  - realign → HUNT.
  - enable = 0 → IDLE.
  - If both happen in the same cycle, enable = 0 wins.
  - realign while in HUNT or VERIFY → HUNT, and the match counter restarts.
- relock_cnt:
  - Increments on the LOCKED→HUNT transition only; LOCKED→IDLE does not count.
  - Saturates at 255.
- Timeout counter:
  - Increments every cycle spent in HUNT or VERIFY.
  - Clears when entering LOCKED or IDLE.
  - Saturates.
  - hunt_timeout is set when the count reaches HUNT_TIMEOUT, and the block keeps hunting.
- clear_errors:
  - Clears hunt_timeout and relock_cnt.
  - If a set or increment happens in the same cycle, the set or increment wins.
- Transition timing: first matching window at cycle t gives state = VERIFY at t+1. With SYNC_COUNT consecutive matches, locked = 1 at t+SYNC_COUNT.

Decomposition:
- Package hsci_align_pkg holds:
  - typedef enum logic [1:0] align_state_t {IDLE, HUNT, VERIFY, LOCKED};
  - localparam ALIGN_CNT_W = 16.
- Sub-module hsci_byte_window:
  - contains the prev register, the 16-bit window, the 8:1 candidate mux and the 8-wide parallel compare;
  - outputs match_vec[7:0] and sel_byte[7:0];
  - shares the same clock and reset.
- Top level holds the FSM, counters and output register.

Test Plan:
- Lock at offset 5: reset, enable = 1, din = 8'hB4 constant. Expect state HUNT → VERIFY → LOCKED, offset = 5, locked 4 cycles after the first match, dout = 8'hA5 with dout_valid = 1.
- Lock at offset 0: din = 8'hA5 constant. Expect offset = 0 and dout = 8'hA5. Then switch din to 8'h3C 8'h12 (the two bytes 8'h3C then 8'h12). Expect dout to be 8'h3C then 8'h12 at 1-cycle latency, and locked to stay high.
- Verify abort: din = B4, B4, 00, B4 ×4. Expect VERIFY→HUNT on the 00, then relock at offset 5, and relock_cnt = 0.
- Relock count: while locked, pulse realign. Expect locked = 0 next cycle and relock_cnt = 1. Pulse realign and drive enable = 0 in the same cycle. Expect IDLE with relock_cnt unchanged.
- Timeout: HUNT_TIMEOUT = 16, din = 8'h00. Expect hunt_timeout = 1 after 16 HUNT cycles. Pulse clear_errors. Expect flag = 0 and it does not re-set, because the counter is saturated and is only cleared by entering IDLE or LOCKED.
- Reset mid-lock: assert hsci_rst_sync for 1 cycle while LOCKED. Expect next cycle to be IDLE with all outputs 0, then a re-hunt with no timeout.

Source files
------------

// File: rtl/hsci_align_pkg.sv
// Shared types and helpers for the HSCI MISO byte aligner.
package hsci_align_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

    localparam int ALIGN_CNT_W = 16;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hsci_byte_window.sv
// Two-byte sliding window over the raw ISERDES stream: keeps the previous
// byte, forms all eight bit-shifted candidates and compares each against the
// training byte in parallel.
module hsci_byte_window
    import hsci_align_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = 8'hA5
) (
    input  logic       hsci_pclk,
    input  logic       hsci_rst_sync,
    input  logic [7:0] din,
    input  logic [2:0] sel,
    output logic [7:0] match_vec,
    output logic [7:0] sel_byte
);

    logic [7:0]  prev_p1;
    logic [15:0] win;
    logic [7:0]  cand [8];

    // Previous raw byte; the window spans it and the current byte.
    always_ff @(posedge hsci_pclk) begin
        if (hsci_rst_sync) begin
            prev_p1 <= 8'h00;
        end else begin
            prev_p1 <= din;
        end
    end

    assign win = {prev_p1, din};

    // All eight candidate alignments and their compare against the pattern.
    always_comb begin
        match_vec = 8'h00;
        for (int k = 0; k < 8; k++) begin
            cand[k]      = win[k +: 8];
            match_vec[k] = (win[k +: 8] == SYNC_PATTERN);
        end
    end

    assign sel_byte = cand[sel];

endmodule

// File: rtl/hsci_miso_aligner.sv
// HSCI MISO byte aligner: hunts for the training byte at any bit offset,
// confirms it over consecutive bytes, then streams byte-aligned data with
// lock status, a sticky hunt timeout and a saturating relock counter.
module hsci_miso_aligner
    import hsci_align_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = 8'hA5,
    parameter int         SYNC_COUNT   = 4,
    parameter int         HUNT_TIMEOUT = 4096
) (
    input  logic       hsci_pclk,
    input  logic       hsci_rst_sync,
    input  logic       enable,
    input  logic       realign,
    input  logic       clear_errors,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       locked,
    output logic [2:0] offset,
    output logic [1:0] state,
    output logic       hunt_timeout,
    output logic [7:0] relock_cnt
);

    localparam logic [3:0]             SYNC_CNT_L = 4'(SYNC_COUNT);
    localparam logic [ALIGN_CNT_W-1:0] TO_LIM     = ALIGN_CNT_W'(HUNT_TIMEOUT);
    localparam logic [ALIGN_CNT_W-1:0] TO_ONE     = ALIGN_CNT_W'(1);

    align_state_t            state_q, state_d;
    logic [2:0]              offset_q, offset_d;
    logic [3:0]              mcnt_q, mcnt_d;
    logic [3:0]              mcnt_inc;
    logic [ALIGN_CNT_W-1:0]  to_cnt_q;
    logic                    to_flag_q;
    logic [7:0]              relock_q;
    logic [7:0]              dout_p1;
    logic [7:0]              match_vec;
    logic [7:0]              sel_byte;
    logic                    in_hunt;
    logic                    to_reach;
    logic                    to_clear;
    logic                    relock_inc;

    hsci_byte_window #(
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_window (
        .hsci_pclk     (hsci_pclk),
        .hsci_rst_sync (hsci_rst_sync),
        .din           (din),
        .sel           (offset_q),
        .match_vec     (match_vec),
        .sel_byte      (sel_byte)
    );

    assign mcnt_inc = mcnt_q + 4'd1;

    // Next-state logic: per-state hunt/verify decisions, then enable and
    // realign overrides (enable low beats realign).
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        mcnt_d   = mcnt_q;
        case (state_q)
            IDLE: begin
                offset_d = 3'd0;
                mcnt_d   = 4'd0;
                state_d  = HUNT;
            end
            HUNT: begin
                if (|match_vec) begin
                    offset_d = lowest_set(match_vec);
                    mcnt_d   = 4'd1;
                    state_d  = VERIFY;
                end
            end
            VERIFY: begin
                if (match_vec[offset_q]) begin
                    mcnt_d = mcnt_inc;
                    if (mcnt_inc == SYNC_CNT_L) begin
                        state_d = LOCKED;
                    end
                end else begin
                    mcnt_d  = 4'd0;
                    state_d = HUNT;
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d  = IDLE;
            offset_d = 3'd0;
            mcnt_d   = 4'd0;
        end else if (realign && (state_q != IDLE)) begin
            state_d = HUNT;
            mcnt_d  = 4'd0;
        end
    end

    assign in_hunt    = (state_q == HUNT) || (state_q == VERIFY);
    assign to_clear   = (state_d == IDLE) || (state_d == LOCKED);
    // Counter saturates at the limit, so the flag is set exactly once per
    // trip through the limit; clearing the flag cannot re-arm it.
    assign to_reach   = in_hunt && (to_cnt_q != TO_LIM) && ((to_cnt_q + TO_ONE) == TO_LIM);
    assign relock_inc = (state_q == LOCKED) && (state_d == HUNT);

    // State, offset and match counter registers.
    always_ff @(posedge hsci_pclk) begin
        if (hsci_rst_sync) begin
            state_q  <= IDLE;
            offset_q <= 3'd0;
            mcnt_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            mcnt_q   <= mcnt_d;
        end
    end

    // Hunt timeout counter and sticky flag; a set beats a same-cycle clear.
    always_ff @(posedge hsci_pclk) begin
        if (hsci_rst_sync) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if (to_clear) begin
                to_cnt_q <= '0;
            end else if (in_hunt && (to_cnt_q != TO_LIM)) begin
                to_cnt_q <= to_cnt_q + TO_ONE;
            end

            if (to_reach) begin
                to_flag_q <= 1'b1;
            end else if (clear_errors) begin
                to_flag_q <= 1'b0;
            end
        end
    end

    // Saturating count of LOCKED to HUNT transitions; increment beats clear.
    always_ff @(posedge hsci_pclk) begin
        if (hsci_rst_sync) begin
            relock_q <= 8'h00;
        end else if (relock_inc) begin
            if (relock_q != 8'hFF) begin
                relock_q <= relock_q + 8'd1;
            end
        end else if (clear_errors) begin
            relock_q <= 8'h00;
        end
    end

    // Output stage: aligned byte one cycle after the window, zero unless the
    // FSM will be LOCKED so dout never shows data alongside dout_valid low.
    always_ff @(posedge hsci_pclk) begin
        if (hsci_rst_sync) begin
            dout_p1 <= 8'h00;
        end else if (state_d == LOCKED) begin
            dout_p1 <= sel_byte;
        end else begin
            dout_p1 <= 8'h00;
        end
    end

    assign dout         = dout_p1;
    assign locked       = (state_q == LOCKED);
    assign dout_valid   = (state_q == LOCKED);
    assign offset       = offset_q;
    assign state        = state_q;
    assign hunt_timeout = to_flag_q;
    assign relock_cnt   = relock_q;

endmodule

// File: tb/tb_hsci_miso_aligner.sv
// Directed bench for the HSCI MISO aligner with hand-computed expectations.
module tb_hsci_miso_aligner;

    logic       hsci_pclk;
    logic       hsci_rst_sync;
    logic       enable;
    logic       realign;
    logic       clear_errors;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       locked;
    logic [2:0] offset;
    logic [1:0] state;
    logic       hunt_timeout;
    logic [7:0] relock_cnt;

    int checks;
    int errors;

    hsci_miso_aligner #(
        .SYNC_PATTERN (8'hA5),
        .SYNC_COUNT   (4),
        .HUNT_TIMEOUT (16)
    ) dut (
        .hsci_pclk     (hsci_pclk),
        .hsci_rst_sync (hsci_rst_sync),
        .enable        (enable),
        .realign       (realign),
        .clear_errors  (clear_errors),
        .din           (din),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .locked        (locked),
        .offset        (offset),
        .state         (state),
        .hunt_timeout  (hunt_timeout),
        .relock_cnt    (relock_cnt)
    );

    initial hsci_pclk = 1'b0;
    always #5 hsci_pclk = ~hsci_pclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge hsci_pclk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [7:0] d);
        hsci_rst_sync = 1'b1;
        enable        = 1'b0;
        realign       = 1'b0;
        clear_errors  = 1'b0;
        din           = d;
        tick(2);
        hsci_rst_sync = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset state
        do_reset(8'hB4);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_dout", 16'(dout), 16'h00);
        chk("rst_valid", 16'(dout_valid), 16'd0);
        chk("rst_locked", 16'(locked), 16'd0);
        chk("rst_offset", 16'(offset), 16'd0);
        chk("rst_timeout", 16'(hunt_timeout), 16'd0);
        chk("rst_relock", 16'(relock_cnt), 16'd0);

        // Lock at offset 5 with constant B4
        enable = 1'b1;
        tick(1);
        chk("o5_hunt", 16'(state), 16'd1);
        tick(1);
        chk("o5_verify", 16'(state), 16'd2);
        chk("o5_offset", 16'(offset), 16'd5);
        tick(2);
        chk("o5_not_yet", 16'(locked), 16'd0);
        tick(1);
        chk("o5_locked", 16'(locked), 16'd1);
        chk("o5_state", 16'(state), 16'd3);
        chk("o5_dout", 16'(dout), 16'hA5);
        chk("o5_valid", 16'(dout_valid), 16'd1);

        // Lock at offset 0 with constant A5, then pass-through data
        do_reset(8'hA5);
        enable = 1'b1;
        tick(5);
        chk("o0_locked", 16'(locked), 16'd1);
        chk("o0_offset", 16'(offset), 16'd0);
        chk("o0_dout", 16'(dout), 16'hA5);
        din = 8'h3C;
        tick(1);
        chk("o0_d3c", 16'(dout), 16'h3C);
        din = 8'h12;
        tick(1);
        chk("o0_d12", 16'(dout), 16'h12);
        chk("o0_still", 16'(locked), 16'd1);

        // Verify abort: B4, B4, 00, then B4 onwards
        do_reset(8'hB4);
        enable = 1'b1;
        tick(1);
        tick(1);
        chk("ab_verify", 16'(state), 16'd2);
        din = 8'h00;
        tick(1);
        chk("ab_hunt", 16'(state), 16'd1);
        din = 8'hB4;
        tick(1);
        chk("ab_nomatch", 16'(state), 16'd1);
        tick(1);
        chk("ab_reverify", 16'(state), 16'd2);
        tick(2);
        chk("ab_not_yet", 16'(locked), 16'd0);
        tick(1);
        chk("ab_locked", 16'(locked), 16'd1);
        chk("ab_offset", 16'(offset), 16'd5);
        chk("ab_relock", 16'(relock_cnt), 16'd0);

        // Relock count via realign, then realign together with enable low
        realign = 1'b1;
        tick(1);
        realign = 1'b0;
        chk("rl_unlocked", 16'(locked), 16'd0);
        chk("rl_state", 16'(state), 16'd1);
        chk("rl_cnt1", 16'(relock_cnt), 16'd1);
        chk("rl_dout0", 16'(dout), 16'h00);
        tick(4);
        chk("rl_relocked", 16'(locked), 16'd1);
        chk("rl_timeout", 16'(hunt_timeout), 16'd0);
        realign = 1'b1;
        enable  = 1'b0;
        tick(1);
        realign = 1'b0;
        chk("rl_idle", 16'(state), 16'd0);
        chk("rl_cnt_hold", 16'(relock_cnt), 16'd1);
        chk("rl_off0", 16'(offset), 16'd0);
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        chk("rl_cleared", 16'(relock_cnt), 16'd0);

        // Hunt timeout with no training pattern
        do_reset(8'h00);
        enable = 1'b1;
        tick(1);
        tick(15);
        chk("to_before", 16'(hunt_timeout), 16'd0);
        tick(1);
        chk("to_set", 16'(hunt_timeout), 16'd1);
        chk("to_hunting", 16'(state), 16'd1);
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        chk("to_cleared", 16'(hunt_timeout), 16'd0);
        tick(20);
        chk("to_no_reset", 16'(hunt_timeout), 16'd0);

        // Lock from the hunting state, then reset while locked
        din = 8'hA5;
        tick(4);
        chk("rm_locked", 16'(locked), 16'd1);
        chk("rm_dout", 16'(dout), 16'hA5);
        hsci_rst_sync = 1'b1;
        tick(1);
        hsci_rst_sync = 1'b0;
        chk("rm_state", 16'(state), 16'd0);
        chk("rm_dout0", 16'(dout), 16'h00);
        chk("rm_valid0", 16'(dout_valid), 16'd0);
        chk("rm_locked0", 16'(locked), 16'd0);
        chk("rm_offset0", 16'(offset), 16'd0);
        tick(1);
        chk("rm_rehunt", 16'(state), 16'd1);
        tick(4);
        chk("rm_relock", 16'(locked), 16'd1);
        chk("rm_no_to", 16'(hunt_timeout), 16'd0);
        chk("rm_relock_cnt", 16'(relock_cnt), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
